// File: rtl/bft_cmd_pkg.sv
// Shared definitions for the BFT traffic clients.
//  - Cmd_* broadcast command encodings (6-bit cmd bus)
//  - PAT_* destination pattern selectors for random runs
//  - packet field offset helpers: {v, last, addr[A_W-1:0], data[D_W-1:0]}
//  - cmd_fire(): decodes a directed one-shot command for a given leaf
package bft_cmd_pkg;

  localparam logic [5:0] Cmd_IDLE = 6'd0;
  localparam logic [5:0] Cmd_RND  = 6'd1;
  localparam logic [5:0] Cmd_01   = 6'd2;  // leaf 0 sends one packet to leaf 1
  localparam logic [5:0] Cmd_10   = 6'd3;  // leaf 1 -> leaf 0
  localparam logic [5:0] Cmd_23   = 6'd4;  // leaf 2 -> leaf 3
  localparam logic [5:0] Cmd_32   = 6'd5;  // leaf 3 -> leaf 2

  localparam int PAT_RANDOM  = 0;
  localparam int PAT_BITREV  = 1;
  localparam int PAT_TORNADO = 2;

  typedef struct packed {
    logic        fire;
    logic [15:0] dst;
  } fire_t;

  function automatic int pkt_v_pos(input int a_w, input int d_w);
    return a_w + d_w + 1;
  endfunction

  function automatic int pkt_last_pos(input int a_w, input int d_w);
    return a_w + d_w;
  endfunction

  function automatic int pkt_addr_lsb(input int d_w);
    return d_w;
  endfunction

  // Directed commands fire only in the leaf named as source.
  function automatic fire_t cmd_fire(input logic [5:0] cmd, input logic [15:0] posx);
    fire_t r;
    r.fire = 1'b0;
    r.dst  = 16'd0;
    case (cmd)
      Cmd_01: if (posx == 16'd0) begin r.fire = 1'b1; r.dst = 16'd1; end
      Cmd_10: if (posx == 16'd1) begin r.fire = 1'b1; r.dst = 16'd0; end
      Cmd_23: if (posx == 16'd2) begin r.fire = 1'b1; r.dst = 16'd3; end
      Cmd_32: if (posx == 16'd3) begin r.fire = 1'b1; r.dst = 16'd2; end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bft_lfsr32.sv
// 32-bit Galois LFSR, polynomial x^32 + x^22 + x^2 + x + 1 (right-shift form).
//  clk   in   clock
//  rst   in   async active-high reset, loads SEED
//  ce    in   advance enable
//  state out  current LFSR value
module bft_lfsr32 #(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  output logic [31:0] state
);

  logic [31:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (ce) state_d = {1'b0, state_q[31:1]} ^ (state_q[0] ? 32'h8020_0003 : 32'h0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SEED;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/bft_client.sv
// Per-leaf traffic endpoint of the deflection BFT.
// Decodes the broadcast cmd bus, injects packets through a single output slot,
// and counts/checks packets delivered by the leaf switch.
//  clk  in   clock
//  rst  in   async active-high reset
//  ce   in   clock enable; 0 freezes all state
//  cmd  in   broadcast command (Cmd_*)
//  out  out  {v, last, addr, data} to switch
//  bp   in   switch backpressure (1 = out not taken)
//  in   in   packet from switch, same format
//  done out  injection quota met, slot empty
//  err  out  sticky: misrouted packet received
//  rcv  out  saturating count of received packets
module bft_client
  import bft_cmd_pkg::*;
#(
  parameter int N     = 512,
  parameter int D_W   = 32,
  parameter int A_W   = $clog2(N) + 1,
  parameter int POSX  = 0,
  parameter int WRAP  = 1,
  parameter int LIMIT = 512,
  parameter int RATE  = 100,
  parameter int PAT   = PAT_RANDOM
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic [5:0]           cmd,
  output logic [A_W+D_W+1:0]   out,
  input  logic                 bp,
  input  logic [A_W+D_W+1:0]   in,
  output logic                 done,
  output logic                 err,
  output logic [15:0]          rcv
);

  localparam int PKT_W  = A_W + D_W + 2;
  localparam int V_POS  = pkt_v_pos(A_W, D_W);
  localparam int A_LSB  = pkt_addr_lsb(D_W);
  localparam int S_W    = $clog2(LIMIT + 1);
  localparam int L_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [31:0]    POSX_V  = 32'(POSX);
  localparam logic [S_W-1:0] LIMIT_V = S_W'(LIMIT);

  typedef enum logic [1:0] {ST_IDLE, ST_RND, ST_DIR, ST_DONE} state_e;

  state_e             state_q, state_d;
  logic [PKT_W-1:0]   slot_q, slot_d;
  logic [S_W-1:0]     sent_q, sent_d;
  logic [15:0]        rcv_q, rcv_d;
  logic               err_q, err_d;
  logic [31:0]        lfsr;

  logic               accept, slot_free, gate, dst_ok, rnd_go, load_rnd, load_dir;
  logic [S_W-1:0]     sent_aft;
  logic [31:0]        dst_raw;
  logic [15:0]        seq16;
  logic [D_W-1:0]     payload;
  fire_t              cf;
  logic               in_v;
  logic [A_W-1:0]     in_addr;

  bft_lfsr32 #(.SEED({POSX_V[30:0], 1'b1})) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
    .state (lfsr)
  );

  always_comb begin
    accept    = slot_q[V_POS] & ~bp;
    // A new packet may load into an empty slot or replace one leaving this edge.
    slot_free = ~slot_q[V_POS] | accept;
    sent_aft  = (accept && sent_q != LIMIT_V) ? sent_q + 1'b1 : sent_q;
    cf        = cmd_fire(cmd, 16'(POSX));
    gate      = ({25'd0, lfsr[6:0]} % 32'd100) < 32'(RATE);

    dst_ok  = 1'b1;
    dst_raw = 32'd0;
    case (PAT)
      PAT_BITREV: for (int i = 0; i < L_W; i++) dst_raw[i] = POSX_V[L_W-1-i];
      PAT_TORNADO: dst_raw = (POSX_V + 32'(N / 2)) % 32'(N);
      default: begin
        if (WRAP != 0) dst_raw = lfsr % 32'(N);
        else begin
          // Out-of-range draw: skip this cycle, the LFSR supplies a new value next cycle.
          dst_raw = 32'(lfsr[A_W-1:0]);
          dst_ok  = dst_raw < 32'(N);
        end
      end
    endcase
    if (dst_raw == POSX_V) dst_raw = (POSX_V + 32'd1) % 32'(N);

    rnd_go   = (cmd == Cmd_RND) && (state_q == ST_IDLE || state_q == ST_RND);
    load_rnd = rnd_go && slot_free && (sent_aft < LIMIT_V) && gate && dst_ok;
    load_dir = (state_q == ST_IDLE) && cf.fire && slot_free;

    // seq numbers packets by how many have been accepted before this one.
    seq16   = 16'(sent_aft);
    payload = {A_W'(POSX), (D_W-A_W)'(seq16)};

    slot_d = slot_q;
    if (accept)   slot_d = '0;
    if (load_rnd) slot_d = {1'b1, (sent_aft == LIMIT_V - 1'b1), A_W'(dst_raw), payload};
    if (load_dir) slot_d = {1'b1, 1'b0, A_W'(cf.dst), payload};

    sent_d = sent_aft;

    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd == Cmd_RND) state_d = ST_RND;
               else if (load_dir) state_d = ST_DIR;
      ST_RND:  if (cmd != Cmd_RND) state_d = ST_IDLE;
      ST_DIR:  if (accept) state_d = ST_IDLE;
      default: ;
    endcase
    if (state_d == ST_RND && sent_aft == LIMIT_V && !slot_d[V_POS]) state_d = ST_DONE;

    in_v    = in[V_POS];
    in_addr = in[A_LSB +: A_W];
    rcv_d   = (in_v && rcv_q != 16'hFFFF) ? rcv_q + 16'd1 : rcv_q;
    err_d   = err_q | (in_v && in_addr != A_W'(POSX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      sent_q  <= '0;
      rcv_q   <= '0;
      err_q   <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      slot_q  <= slot_d;
      sent_q  <= sent_d;
      rcv_q   <= rcv_d;
      err_q   <= err_d;
    end
  end

  assign out  = slot_q;
  assign done = (state_q == ST_DONE);
  assign err  = err_q;
  assign rcv  = rcv_q;

endmodule
